// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift-mode encodings and stage-count helper.
package shifter_pkg;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    function automatic int shw_of(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Operand/result handshake bundle: master is the producer/consumer, slave is the shifter.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 16,
    parameter int SHW   = shifter_pkg::shw_of(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/pipelined_barrel_shifter_stage.sv
// One log2 step of the barrel shifter: shifts by SHIFT when en_i is set, else passes through.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHIFT = 1
) (
    input  logic [1:0]       mode_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ovf_i,
    output logic [WIDTH-1:0] data_o,
    output logic             ovf_o
);
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = data_i;
        ovf_o   = 1'b0;
        case (mode_i)
            MODE_LSL: begin
                shifted = data_i << SHIFT;
                ovf_o   = ovf_i | (en_i & (|data_i[WIDTH-1 -: SHIFT]));
            end
            MODE_LSR: shifted = data_i >> SHIFT;
            // Arithmetic shift replicates the MSB, so the sign survives every stage.
            MODE_ASR: shifted = $signed(data_i) >>> SHIFT;
            default:  shifted = {data_i[WIDTH-1-SHIFT:0], data_i[WIDTH-1 -: SHIFT]};
        endcase
        data_o = en_i ? shifted : data_i;
    end
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SHW registered stages, stage k shifts by 2^k; global stall on output backpressure.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = shw_of(WIDTH)
) (
    input logic                       clk,
    input logic                       rst_n,
    pipelined_barrel_shifter_if.slave bus
);
    logic             en;
    logic [WIDTH-1:0] data_in [SHW];
    logic [SHW-1:0]   amt_in  [SHW];
    logic [1:0]       mode_in [SHW];
    logic [SHW-1:0]   ovf_in;

    logic [WIDTH-1:0] data_d [SHW];
    logic [WIDTH-1:0] data_q [SHW];
    logic [SHW-1:0]   ovf_d, ovf_q;
    logic [SHW-1:0]   vld_pipe_d, vld_pipe_q;
    logic [SHW-1:0]   amt_d  [SHW-1];
    logic [SHW-1:0]   amt_q  [SHW-1];
    logic [1:0]       mode_d [SHW-1];
    logic [1:0]       mode_q [SHW-1];

    // A held result freezes the whole pipe; nothing is collapsed.
    assign en            = ~(bus.out_valid & ~bus.out_ready);
    assign bus.in_ready  = en;
    assign bus.out_valid = vld_pipe_q[SHW-1];
    assign bus.out_data  = data_q[SHW-1];
    assign bus.out_ovf   = ovf_q[SHW-1];

    always_comb begin
        data_in[0] = bus.in_data;
        amt_in[0]  = bus.in_amt;
        mode_in[0] = bus.in_mode;
        ovf_in[0]  = 1'b0;
        for (int k = 1; k < SHW; k++) begin
            data_in[k] = data_q[k-1];
            amt_in[k]  = amt_q[k-1];
            mode_in[k] = mode_q[k-1];
            ovf_in[k]  = ovf_q[k-1];
        end
        for (int k = 0; k < SHW-1; k++) begin
            amt_d[k]  = amt_in[k];
            mode_d[k] = mode_in[k];
        end
        vld_pipe_d = {vld_pipe_q[SHW-2:0], bus.in_valid};
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(.WIDTH(WIDTH), .SHIFT(1 << k)) u_stage (
            .mode_i (mode_in[k]),
            .en_i   (amt_in[k][k]),
            .data_i (data_in[k]),
            .ovf_i  (ovf_in[k]),
            .data_o (data_d[k]),
            .ovf_o  (ovf_d[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '{default: '0};
            ovf_q      <= '0;
            vld_pipe_q <= '0;
            amt_q      <= '{default: '0};
            mode_q     <= '{default: '0};
        end else if (en) begin
            data_q     <= data_d;
            ovf_q      <= ovf_d;
            vld_pipe_q <= vld_pipe_d;
            amt_q      <= amt_d;
            mode_q     <= mode_d;
        end
    end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: per-scenario tasks plus an in-order result scoreboard.
module tb_pipelined_barrel_shifter;
    import shifter_pkg::*;

    localparam int W = 16;
    localparam int S = 4;

    typedef struct packed { logic [W-1:0] d; logic o; } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   pops = 0;
    exp_t exp_q[$];

    pipelined_barrel_shifter_if #(.WIDTH(W), .SHW(S)) bus();
    pipelined_barrel_shifter #(.WIDTH(W), .SHW(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [W-1:0] d, input logic [S-1:0] a, input logic [1:0] m);
        logic [2*W-1:0] w;
        exp_t r;
        r.o = 1'b0;
        case (m)
            MODE_LSL: begin w = {{W{1'b0}}, d} << a; r.d = w[W-1:0]; r.o = |w[2*W-1:W]; end
            MODE_LSR: r.d = d >> a;
            MODE_ASR: r.d = $signed(d) >>> a;
            default:  begin w = {d, d} << a; r.d = w[2*W-1:W]; end
        endcase
        return r;
    endfunction

    // Scoreboard: every accepted result is compared with the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            exp_t e;
            total++;
            pops++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: unexpected result data=%h ovf=%b", bus.out_data, bus.out_ovf);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_data !== e.d || bus.out_ovf !== e.o) begin
                    bad++;
                    $display("FAIL sb_result: got data=%h ovf=%b, want data=%h ovf=%b",
                             bus.out_data, bus.out_ovf, e.d, e.o);
                end
            end
        end
    end

    // Called at posedge+1; presents one operand until accepted, returns at posedge+1 with in_valid low.
    task automatic send(input logic [W-1:0] d, input logic [S-1:0] a, input logic [1:0] m, input exp_t e);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_mode  = m;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%b, want 1", bus.in_ready);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: outstanding=%0d, want 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_mode   = MODE_LSL;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        total += 4;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        if (bus.out_data !== 16'h0) begin bad++; $display("FAIL rst_out_data: got %h want 0000", bus.out_data); end
        if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL rst_out_ovf: got %b want 0", bus.out_ovf); end
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lsl();
        send(16'h0001, 4'd15, MODE_LSL, '{d: 16'h8000, o: 1'b0});
        repeat (3) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lsl_early: out_valid=%b want 0", bus.out_valid); end
        end
        @(negedge clk);
        total += 3;
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL lsl_latency: out_valid=%b want 1", bus.out_valid); end
        if (bus.out_data !== 16'h8000) begin bad++; $display("FAIL lsl_data: got %h want 8000", bus.out_data); end
        if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL lsl_ovf: got %b want 0", bus.out_ovf); end
        @(posedge clk);
        #1;
        send(16'h8001, 4'd1, MODE_LSL, '{d: 16'h0002, o: 1'b1});
        wait_drain();
    endtask

    task automatic test_modes();
        exp_t tab[4];
        tab[0] = '{d: 16'h00F0, o: 1'b1};
        tab[1] = '{d: 16'h0F00, o: 1'b0};
        tab[2] = '{d: 16'hFF00, o: 1'b0};
        tab[3] = '{d: 16'h00FF, o: 1'b0};
        for (int m = 0; m < 4; m++) begin
            send(16'hF00F, 4'd4, 2'(m), tab[m]);
            send(16'hF00F, 4'd0, 2'(m), '{d: 16'hF00F, o: 1'b0});
        end
        send(16'h8000, 4'd15, MODE_ASR, '{d: 16'hFFFF, o: 1'b0});
        send(16'h8000, 4'd15, MODE_LSR, '{d: 16'h0001, o: 1'b0});
        send(16'h0003, 4'd15, MODE_ROL, '{d: 16'h8001, o: 1'b0});
        send(16'h0003, 4'd15, MODE_LSL, '{d: 16'h8000, o: 1'b1});
        wait_drain();
    endtask

    task automatic test_back_to_back();
        time t0;
        int  p0;
        logic [W-1:0] d;
        logic [S-1:0] a;
        logic [1:0]   m;
        t0 = $time;
        p0 = pops;
        for (int i = 0; i < 64; i++) begin
            d = W'($urandom);
            a = (i % 8 == 0) ? 4'd15 : S'($urandom_range(0, 15));
            m = 2'($urandom_range(0, 3));
            send(d, a, m, model(d, a, m));
        end
        total++;
        if ($time - t0 != 640) begin bad++; $display("FAIL b2b_rate: took %0t want 640", $time - t0); end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        total += 2;
        if (pops - p0 != 64) begin bad++; $display("FAIL b2b_count: got %0d results want 64", pops - p0); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_left: outstanding=%0d want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        exp_t first;
        exp_t e5;
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] d = W'(16'h1111 * (i + 1));
            if (i == 0) first = model(d, S'(i), 2'(i));
            send(d, S'(i), 2'(i), model(d, S'(i), 2'(i)));
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hA5C3;
        bus.in_amt    = 4'd7;
        bus.in_mode   = MODE_ROL;
        e5 = model(16'hA5C3, 4'd7, MODE_ROL);
        repeat (5) begin
            @(negedge clk);
            total += 4;
            if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
            if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %b want 1", bus.out_valid); end
            if (bus.out_data !== first.d) begin bad++; $display("FAIL bp_hold_data: got %h want %h", bus.out_data, first.d); end
            if (bus.out_ovf !== first.o) begin bad++; $display("FAIL bp_hold_ovf: got %b want %b", bus.out_ovf, first.o); end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b want 1", bus.in_ready);
        end else begin
            exp_q.push_back(e5);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_bubbles();
        logic [7:0] ov;
        logic [7:0] want;
        want = 8'b0101_0000;
        fork
            begin
                send(16'h1234, 4'd3, MODE_LSR, model(16'h1234, 4'd3, MODE_LSR));
                @(posedge clk);
                #1;
                send(16'h4321, 4'd5, MODE_ROL, model(16'h4321, 4'd5, MODE_ROL));
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    ov[i] = bus.out_valid;
                end
            end
        join
        for (int i = 0; i < 8; i++) begin
            total++;
            if (ov[i] !== want[i]) begin bad++; $display("FAIL bubble_%0d: out_valid=%b want %b", i, ov[i], want[i]); end
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int p0;
        send(16'h1234, 4'd0, MODE_LSL, '{d: 16'h1234, o: 1'b0});
        send(16'h00FF, 4'd2, MODE_LSL, model(16'h00FF, 4'd2, MODE_LSL));
        send(16'h8888, 4'd1, MODE_ASR, model(16'h8888, 4'd1, MODE_ASR));
        send(16'h0F0F, 4'd9, MODE_ROL, model(16'h0F0F, 4'd9, MODE_ROL));
        bus.out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rm_pre: out_valid=%b want 1", bus.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total += 4;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_out_valid: got %b want 0", bus.out_valid); end
        if (bus.out_data !== 16'h0) begin bad++; $display("FAIL rm_out_data: got %h want 0000", bus.out_data); end
        if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL rm_out_ovf: got %b want 0", bus.out_ovf); end
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rm_in_ready: got %b want 1", bus.in_ready); end
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        p0 = pops;
        repeat (8) @(negedge clk);
        total++;
        if (pops != p0) begin bad++; $display("FAIL rm_stale: got %0d results want 0", pops - p0); end
        @(posedge clk);
        #1;
        send(16'h0101, 4'd4, MODE_LSL, '{d: 16'h1010, o: 1'b0});
        repeat (3) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_early: out_valid=%b want 0", bus.out_valid); end
        end
        @(negedge clk);
        total += 2;
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rm_latency: out_valid=%b want 1", bus.out_valid); end
        if (bus.out_data !== 16'h1010) begin bad++; $display("FAIL rm_data: got %h want 1010", bus.out_data); end
        @(posedge clk);
        #1;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_lsl();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
